// File: rtl/lfsr_prng_gen.sv
// lfsr_prng_gen: Fibonacci LFSR pseudo-random word generator.
// Each accepted request steps the LFSR SHIFTS times, then publishes the low
// OUT_W bits of the final state as a word, together with a registered
// (word < thresh) hit flag.
//
// Handshake: req is a level sampled only while idle. Once accepted, busy is
// high for exactly SHIFTS cycles, then valid pulses for one cycle with word/hit
// updated. req seen while busy is ignored (not queued). seed_load aborts any
// word in flight and suppresses its valid.
//
// Optional build macro: LFSR_ZERO_GUARD_EN
//   defined   -> a zero seed loads SEED, and a zero state is replaced by SEED.
//   undefined -> seed_in loaded verbatim; a zero seed locks the LFSR at 0.
module lfsr_prng_gen #(
    parameter int               WIDTH  = 10,
    parameter logic [WIDTH-1:0] TAPS   = 10'h240,
    parameter logic [WIDTH-1:0] SEED   = 10'd88,
    parameter int               OUT_W  = 5,
    parameter int               SHIFTS = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [OUT_W-1:0] thresh,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] word,
    output logic             hit,
    output logic [WIDTH-1:0] state_o
);

    localparam int CNT_W = $clog2(SHIFTS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } fsm_t;

    fsm_t             fsm_q;
    fsm_t             fsm_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_step;
    logic [WIDTH-1:0] seed_mux;
    logic             lfsr_zero;
    logic             last_step;
    logic             valid_q;
    logic [OUT_W-1:0] word_q;
    logic             hit_q;

    // One Fibonacci step: shift left, feedback is the parity of tapped bits.
    assign lfsr_step = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

    // The SHIFTS-th step of a word is the one taken while cnt holds SHIFTS-1.
    assign last_step = (fsm_q == SHIFT) && (cnt_q == CNT_W'(SHIFTS - 1));

`ifdef LFSR_ZERO_GUARD_EN
    // Zero would lock the XOR LFSR, so substitute the default seed.
    assign seed_mux  = (seed_in == '0) ? SEED : seed_in;
    assign lfsr_zero = (lfsr_q == '0);
`else
    // Seed is taken verbatim; a zero seed intentionally locks the LFSR.
    assign seed_mux  = seed_in;
    assign lfsr_zero = 1'b0;
`endif

    // FSM state register: reset and seed_load both return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else if (seed_load) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state: accept req only when idle, leave SHIFT on the last step.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (req) fsm_d = SHIFT;
            SHIFT:   if (last_step) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // FSM outputs: busy is a pure decode of the state register.
    always_comb begin
        busy = (fsm_q == SHIFT);
    end

    // Step counter: counts steps within a word, cleared outside SHIFT.
    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            cnt_q <= '0;
        end else if (fsm_q == SHIFT) begin
            cnt_q <= last_step ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    // LFSR register: advances only in SHIFT; seed_load overrides stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else if (seed_load) begin
            lfsr_q <= seed_mux;
        end else if (lfsr_zero) begin
            lfsr_q <= SEED;
        end else if (fsm_q == SHIFT) begin
            lfsr_q <= lfsr_step;
        end
    end

    // Result registers: word/hit capture on the last step and hold otherwise;
    // thresh is only looked at on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            hit_q   <= 1'b0;
        end else if (seed_load) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= last_step;
            if (last_step) begin
                word_q <= lfsr_step[OUT_W-1:0];
                hit_q  <= (lfsr_step[OUT_W-1:0] < thresh);
            end
        end
    end

    assign valid   = valid_q;
    assign word    = word_q;
    assign hit     = hit_q;
    assign state_o = lfsr_q;

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Directed bench for lfsr_prng_gen with default parameters.
// Expected values are hand-derived from x^10+x^7+1 starting at 0x058.
module tb_lfsr_prng_gen;

    logic       clk;
    logic       rst;
    logic       seed_load;
    logic [9:0] seed_in;
    logic       req;
    logic [4:0] thresh;
    logic       busy;
    logic       valid;
    logic [4:0] word;
    logic       hit;
    logic [9:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    lfsr_prng_gen dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .thresh    (thresh),
        .busy      (busy),
        .valid     (valid),
        .word      (word),
        .hit       (hit),
        .state_o   (state_o)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_seed(input logic [9:0] s);
        seed_load = 1'b1;
        seed_in   = s;
        cyc();
        seed_load = 1'b0;
    endtask

    // One full word from state 0x058: states 0x0B1..0x314, word 0x14.
    task automatic do_word(input logic [4:0] th, input logic exp_hit, input string tag);
        logic [9:0] exp_q[$];
        exp_q  = '{10'h0B1, 10'h162, 10'h2C5, 10'h18A, 10'h314};
        thresh = th;
        req    = 1'b1;
        cyc();
        req = 1'b0;
        chk({tag, "_busy_c1"}, busy, 1);
        chk({tag, "_state_c1"}, state_o, 10'h058);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk({tag, "_state"}, state_o, exp_q.pop_front());
            if (i < 4) begin
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_valid_lo"}, valid, 0);
            end
        end
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_word"}, word, 5'h14);
        chk({tag, "_hit"}, hit, exp_hit);
        cyc();
        chk({tag, "_valid_pulse"}, valid, 0);
        chk({tag, "_word_hold"}, word, 5'h14);
    endtask

    initial begin
        int n_words;
        int early;
        int bad_gap;
        int cycle;
        int last;
        int extra_valid;

        rst       = 1'b1;
        seed_load = 1'b0;
        seed_in   = '0;
        req       = 1'b0;
        thresh    = '0;
        cyc();
        cyc();

        // T1 reset values then one default word
        chk("rst_state", state_o, 10'h058);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_word", word, 0);
        chk("rst_hit", hit, 0);
        rst = 1'b0;
        cyc();
        chk("idle_no_step", state_o, 10'h058);
        do_word(5'd0, 1'b0, "t1_th0");

        // T2 threshold boundary
        do_seed(10'h058);
        do_word(5'd20, 1'b0, "t2_th20");
        do_seed(10'h058);
        do_word(5'd21, 1'b1, "t2_th21");

        // T3 seed_load mid-word aborts it
        do_seed(10'h058);
        req = 1'b1;
        cyc();
        req = 1'b0;
        cyc();
        cyc();
        chk("t3_busy_before", busy, 1);
        seed_load = 1'b1;
        seed_in   = 10'h001;
        cyc();
        seed_load = 1'b0;
        chk("t3_busy", busy, 0);
        chk("t3_valid", valid, 0);
        chk("t3_state", state_o, 10'h001);
        chk("t3_word_hold", word, 5'h14);
        chk("t3_hit_hold", hit, 1);
        extra_valid = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (valid) extra_valid++;
        end
        chk("t3_no_valid", extra_valid, 0);
        chk("t3_state_idle", state_o, 10'h001);

        // seed_load and req in the same idle cycle: load wins, req re-sampled
        seed_load = 1'b1;
        seed_in   = 10'h058;
        req       = 1'b1;
        thresh    = 5'd21;
        cyc();
        seed_load = 1'b0;
        chk("sr_busy_dropped", busy, 0);
        chk("sr_state", state_o, 10'h058);
        cyc();
        req = 1'b0;
        chk("sr_busy_resampled", busy, 1);
        for (int i = 0; i < 5; i++) cyc();
        chk("sr_valid", valid, 1);
        chk("sr_word", word, 5'h14);
        chk("sr_hit", hit, 1);
        cyc();

        // T5 zero seed
        do_seed(10'h000);
`ifdef LFSR_ZERO_GUARD_EN
        chk("t5_guard_state", state_o, 10'h058);
        do_word(5'd0, 1'b0, "t5_guard");
`else
        chk("t5_zero_state", state_o, 10'h000);
        thresh = 5'd5;
        req    = 1'b1;
        cyc();
        req = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        chk("t5_zero_valid", valid, 1);
        chk("t5_zero_word", word, 0);
        chk("t5_zero_hit", hit, 1);
        chk("t5_zero_locked", state_o, 10'h000);
        cyc();
`endif

        // T6 reset mid-word, then T1 reproduces
        do_seed(10'h058);
        thresh = 5'd21;
        req    = 1'b1;
        cyc();
        req = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_state", state_o, 10'h058);
        chk("t6_busy", busy, 0);
        chk("t6_valid", valid, 0);
        chk("t6_word", word, 0);
        chk("t6_hit", hit, 0);
        do_word(5'd0, 1'b0, "t6_rerun");

        // T4 req held high: one word per 6 cycles, period of 1023 words
        rst = 1'b1;
        cyc();
        rst     = 1'b0;
        req     = 1'b1;
        n_words = 0;
        early   = 0;
        bad_gap = 0;
        cycle   = 0;
        last    = 0;
        while (n_words < 1023 && cycle < 1023 * 6 + 50) begin
            cyc();
            cycle++;
            if (valid) begin
                n_words++;
                if (cycle - last != 6) bad_gap++;
                last = cycle;
                if (state_o == 10'h058 && n_words < 1023) early++;
            end
        end
        req = 1'b0;
        chk("t4_word_count", n_words, 1023);
        chk("t4_gap_errors", bad_gap, 0);
        chk("t4_early_return", early, 0);
        chk("t4_period_state", state_o, 10'h058);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
